// File: rtl/adders_pkg.sv
// Shared definitions for the adder/ALU datapath blocks.
//   ADD/SUB  : op-mode encodings for the 'sub' input
//   DEF_*    : default operand width and ripple-segment size
//   chunk_ok : legality of a WIDTH/CHUNK split into equal ripple segments
package adders_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic bit chunk_ok(input int w, input int c);
    return (w >= 1) && (c >= 1) && (c <= w) && ((w % c) == 0);
  endfunction
endpackage

// File: rtl/rca_stage.sv
// One pipeline stage of pipe_rca: CHUNK-bit combinational ripple slice
// followed by registered sum chunk, carry-out, overflow and valid bit.
//   clk, rst_n : clock, async active-low reset
//   i_en       : pipeline advance enable
//   i_vld      : valid bit of the slot entering this stage
//   i_c        : carry into the slice
//   i_a, i_b   : operand chunk (i_b already inverted for subtract)
//   o_sum      : registered sum chunk
//   o_c        : registered carry out of the slice
//   o_ovf      : registered carry-in-to-MSB XOR carry-out of the slice
//   o_vld      : registered valid bit
module rca_stage import adders_pkg::*; #(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic             i_c,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_vld
);
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum;

  always_comb begin
    w_c    = '0;
    w_sum  = '0;
    w_c[0] = i_c;
    for (int i = 0; i < CHUNK; i++) begin
      w_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  // Data registers load every enabled cycle regardless of valid; only the
  // valid bit decides whether the slot means anything downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sum <= '0;
      o_c   <= 1'b0;
      o_ovf <= 1'b0;
      o_vld <= 1'b0;
    end else if (i_en) begin
      o_sum <= w_sum;
      o_c   <= w_c[CHUNK];
      o_ovf <= w_c[CHUNK] ^ w_c[CHUNK-1];
      o_vld <= i_vld;
    end
  end
endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// WIDTH bits are split into NSTAGE = WIDTH/CHUNK ripple segments, one per
// stage, with the carry registered between stages.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline enable)
//   a, b, cin, sub      : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready : result handshake
//   s, cout, ovf        : sum/difference, MSB carry-out, signed overflow
module pipe_rca import adders_pkg::*; #(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int CHUNK  = DEF_CHUNK,
  localparam int NSTAGE = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_rca: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic                w_en;
  logic [NSTAGE-1:0]   w_vin, w_cin, w_vld, w_co, w_ovf;
  logic [CHUNK-1:0]    w_sum [NSTAGE];
  // w_ain/w_bin: operands entering stage k; r_a/r_b: same, delayed past it.
  logic [WIDTH-1:0]    w_ain [NSTAGE];
  logic [WIDTH-1:0]    w_bin [NSTAGE];
  logic [WIDTH-1:0]    r_a   [NSTAGE];
  logic [WIDTH-1:0]    r_b   [NSTAGE];
  // r_s[k]: result chunks below k travelling alongside stage k;
  // w_res[k]: those plus the chunk stage k just produced.
  logic [WIDTH-1:0]    w_pre [NSTAGE];
  logic [WIDTH-1:0]    r_s   [NSTAGE];
  logic [WIDTH-1:0]    w_res [NSTAGE];

  assign w_en     = !w_vld[NSTAGE-1] || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_ain[k] = a;
      assign w_bin[k] = (sub == SUB) ? ~b : b;
      assign w_cin[k] = cin ^ sub;
      assign w_vin[k] = in_valid;
      assign w_pre[k] = '0;
    end else begin : g_body
      assign w_ain[k] = r_a[k-1];
      assign w_bin[k] = r_b[k-1];
      assign w_cin[k] = w_co[k-1];
      assign w_vin[k] = w_vld[k-1];
      assign w_pre[k] = w_res[k-1];
    end

    rca_stage #(.CHUNK(CHUNK)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_vld (w_vin[k]),
      .i_c   (w_cin[k]),
      .i_a   (w_ain[k][k*CHUNK +: CHUNK]),
      .i_b   (w_bin[k][k*CHUNK +: CHUNK]),
      .o_sum (w_sum[k]),
      .o_c   (w_co[k]),
      .o_ovf (w_ovf[k]),
      .o_vld (w_vld[k])
    );

    // Chunk k of r_s[k] is always zero, so OR-ing the new chunk in is exact.
    assign w_res[k] = r_s[k] | (WIDTH'(w_sum[k]) << (k*CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end else if (w_en) begin
        r_a[k] <= w_ain[k];
        r_b[k] <= w_bin[k];
        r_s[k] <= w_pre[k];
      end
    end
  end

  assign out_valid = w_vld[NSTAGE-1];
  assign s         = w_res[NSTAGE-1];
  assign cout      = w_co[NSTAGE-1];
  assign ovf       = w_ovf[NSTAGE-1];

  // Operand copies past the last stage and intermediate overflow bits are
  // never consumed.
  logic w_unused;
  assign w_unused = ^{r_a[NSTAGE-1], r_b[NSTAGE-1], w_ovf};
endmodule

// File: tb/tb_pipe_rca.sv
// Directed + random self-checking bench for pipe_rca (WIDTH=16, CHUNK=4/1/16).
module tb_pipe_rca;
  logic        clk, rst_n, in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic [2:0]  ov, ir, co, of;
  logic [15:0] so [3];

  int nassert = 0;
  int nfail   = 0;

  logic [17:0] mem [3][64];
  int          wp  [3];
  int          rp  [3];

  pipe_rca #(.WIDTH(16), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .s(so[0]),
    .cout(co[0]), .ovf(of[0]));
  pipe_rca #(.WIDTH(16), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .s(so[1]),
    .cout(co[1]), .ovf(of[1]));
  pipe_rca #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .s(so[2]),
    .cout(co[2]), .ovf(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {cout, ovf, s}; overflow via sign rule, independent of carry chains
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] eb;
    logic [16:0] full;
    logic        v;
    eb   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, eb} + 17'(ci ^ sb);
    v    = (x[15] == eb[15]) && (full[15] != x[15]);
    return {full[16], v, full[15:0]};
  endfunction

  function automatic logic [31:0] pk(input int d);
    return 32'({co[d], of[d], so[d]});
  endfunction

  // One pair through an empty pipe; checks latency on CHUNK=4 and CHUNK=16.
  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb, input logic [17:0] exp);
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(ir[0]), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_c16_valid"}, 32'(ov[2]), 32'd1);
    chk({tag, "_c16_res"}, pk(2), 32'(exp));
    chk({tag, "_lat1"}, 32'(ov[0]), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(ov[0]), 32'd0);
    tick();
    chk({tag, "_lat3"}, 32'(ov[0]), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(ov[0]), 32'd1);
    chk({tag, "_s"}, 32'(so[0]), 32'(exp[15:0]));
    chk({tag, "_cout"}, 32'(co[0]), 32'(exp[17]));
    chk({tag, "_ovf"}, 32'(of[0]), 32'(exp[16]));
  endtask

  task automatic pop_chk(input int d);
    if (ov[d] && out_ready) begin
      chk("rand_expected_pending", 32'(wp[d] != rp[d]), 32'd1);
      if (wp[d] != rp[d]) begin
        chk("rand_result", pk(d), 32'(mem[d][rp[d][5:0]]));
        rp[d]++;
      end
    end
  endtask

  initial begin
    int idx_in, idx_out, stall_cnt, acc, cyc;
    logic prev_stall;
    logic [15:0] prev_s;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_s", 32'(so[0]), 32'd0);
    chk("rst_cout", 32'(co[0]), 32'd0);
    chk("rst_ovf", 32'(of[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_c1_valid", 32'(ov[1]), 32'd0);
    #4;
    rst_n = 1'b1;

    run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    run_one("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    run_one("ovf_neg",  16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
    run_one("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run_one("sub_cin",  16'h0007, 16'h0005, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0001});

    // back-to-back stream: i + 0xFF*i = i<<8
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      a = 16'(c);
      b = 16'(16'h00FF * c);
      tick();
      chk("stream_valid", 32'(ov[0]), 32'((c >= 3) && (c <= 10)));
      if (ov[0]) chk("stream_s", 32'(so[0]), 32'((c - 3) * 256));
    end
    in_valid = 1'b0;

    // backpressure: out_ready low for cycles 5..7
    idx_in = 0; idx_out = 0; stall_cnt = 0; prev_stall = 1'b0; prev_s = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c < 5) || (c > 7);
      in_valid  = (idx_in < 8);
      a = 16'(idx_in);
      b = 16'(16'h00FF * idx_in);
      #1;
      if (!out_ready && ov[0]) begin
        stall_cnt++;
        chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
        if (prev_stall) chk("bp_s_hold", 32'(so[0]), 32'(prev_s));
      end
      if (ov[0] && out_ready) begin
        chk("bp_order_s", 32'(so[0]), 32'(idx_out * 256));
        chk("bp_flags", 32'({co[0], of[0]}), 32'd0);
        idx_out++;
      end
      if (in_valid && ir[0]) idx_in++;
      prev_stall = !out_ready && ov[0];
      prev_s = so[0];
      tick();
    end
    chk("bp_delivered", 32'(idx_out), 32'd8);
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;

    // mid-stream reset with three transactions in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = 16'(16'h1111 * (c + 1));
      b = 16'h0000;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mrst_pre_valid", 32'(ov[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(ov[0]), 32'd0);
    chk("mrst_s", 32'(so[0]), 32'd0);
    chk("mrst_in_ready", 32'(ir[0]), 32'd1);
    tick();
    rst_n = 1'b1;
    run_one("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0003});

    // clean start for random phase
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      #1;
      for (int d = 0; d < 3; d++) begin
        pop_chk(d);
        if (in_valid && ir[d]) begin
          mem[d][wp[d][5:0]] = model(a, b, cin, sub);
          wp[d]++;
        end
      end
      if (in_valid && ir[0]) acc++;
      cyc++;
      tick();
    end
    chk("rand_accepted", 32'(acc), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int d = 0; d < 3; d++) pop_chk(d);
      tick();
    end
    for (int d = 0; d < 3; d++) chk("rand_drained", 32'(rp[d]), 32'(wp[d]));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
